// File: rtl/ram_arbiter_pkg.sv
// Shared constants, FSM encoding and the byte-merge helper for the RAM arbiter.
// Replaces the old define file: address width, RAM size, full byte-enable mask.
package ram_arbiter_pkg;

    localparam int         RAM_ADDRESS_BITWIDTH = 12;
    localparam int         RAM_SIZE             = 1 << RAM_ADDRESS_BITWIDTH;
    localparam logic [3:0] BE_FULL              = 4'hF;

    typedef enum logic {
        RAMARB_IDLE  = 1'b0,
        RAMARB_MERGE = 1'b1
    } ArbState;

    // Per byte: take the store data where enabled, otherwise keep the old RAM word.
    function automatic logic [31:0] mergeBytes(input logic [3:0]  be,
                                               input logic [31:0] wdata,
                                               input logic [31:0] rdata);
        logic [31:0] merged;
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the IF port, D port and RAM pins seen by the arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDRESS_BITWIDTH
);

    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              ram_wren;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_write_data;
    logic [31:0]       ram_data;

    modport slave (
        input  if_req_valid, if_addr,
        input  d_req_valid, d_we, d_be, d_addr, d_wdata,
        input  ram_data,
        output if_req_ready, if_rvalid, if_rdata,
        output d_req_ready, d_rvalid, d_rdata,
        output ram_wren, ram_address, ram_write_data
    );

    modport master (
        output if_req_valid, if_addr,
        output d_req_valid, d_we, d_be, d_addr, d_wdata,
        output ram_data,
        input  if_req_ready, if_rvalid, if_rdata,
        input  d_req_ready, d_rvalid, d_rdata,
        input  ram_wren, ram_address, ram_write_data
    );

endinterface

// File: rtl/ram_rr_arbiter.sv
// Two-way arbiter: req[0]/gnt[0] is the D port, req[1]/gnt[1] the IF port.
// With rr_en set, a tie goes to whichever port was not granted last; otherwise D wins.
module ram_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       rr_en,
    output logic [1:0] gnt
);

    // ptr_q = 0 favours D, 1 favours IF; it moves on every grant.
    logic ptr_q, ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (rr_en && ptr_q) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
            if (gnt != 2'b00) begin
                ptr_d = gnt[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port word RAM between instruction fetch and load/store,
// turning partial-word stores into a two-cycle read-modify-write.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDRESS_BITWIDTH,
    parameter bit RR_EN  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    ArbState           state_q, state_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ifRvalid_q, ifRvalid_d;
    logic              dRvalid_q, dRvalid_d;

    logic [1:0]        gnt;
    logic              arbEn;
    logic              ramWren;
    logic [ADDR_W-1:0] ramAddress;
    logic [31:0]       ramWriteData;

    assign arbEn = (state_q == RAMARB_IDLE) && !rst;

    ram_rr_arbiter u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   ({bus.if_req_valid, bus.d_req_valid}),
        .en    (arbEn),
        .rr_en (RR_EN),
        .gnt   (gnt)
    );

    assign bus.d_req_ready  = gnt[0];
    assign bus.if_req_ready = gnt[1];

    always_comb begin
        state_d      = state_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        ifRvalid_d   = 1'b0;
        dRvalid_d    = 1'b0;
        ramWren      = 1'b0;
        ramAddress   = '0;
        ramWriteData = '0;

        unique case (state_q)
            RAMARB_IDLE: begin
                if (gnt[1]) begin
                    ramAddress = bus.if_addr & WORD_MASK;
                    ifRvalid_d = 1'b1;
                end else if (gnt[0]) begin
                    if (!bus.d_we) begin
                        ramAddress = bus.d_addr & WORD_MASK;
                        dRvalid_d  = 1'b1;
                    end else if (bus.d_be == BE_FULL) begin
                        ramWren      = 1'b1;
                        ramAddress   = bus.d_addr & WORD_MASK;
                        ramWriteData = bus.d_wdata;
                    end else if (bus.d_be != 4'h0) begin
                        // Partial store: fetch the old word now, merge and write it next cycle.
                        ramAddress = bus.d_addr & WORD_MASK;
                        be_d       = bus.d_be;
                        wdata_d    = bus.d_wdata;
                        addr_d     = bus.d_addr & WORD_MASK;
                        state_d    = RAMARB_MERGE;
                    end
                end
            end
            RAMARB_MERGE: begin
                ramWren      = 1'b1;
                ramAddress   = addr_q;
                ramWriteData = mergeBytes(be_q, wdata_q, bus.ram_data);
                state_d      = RAMARB_IDLE;
            end
        endcase

        // Reset mid-merge must not let the pending write reach the RAM.
        if (rst) begin
            ramWren      = 1'b0;
            ramAddress   = '0;
            ramWriteData = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RAMARB_IDLE;
            be_q       <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            ifRvalid_q <= 1'b0;
            dRvalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            ifRvalid_q <= ifRvalid_d;
            dRvalid_q  <= dRvalid_d;
        end
    end

    assign bus.ram_wren       = ramWren;
    assign bus.ram_address    = ramAddress;
    assign bus.ram_write_data = ramWriteData;

    assign bus.if_rvalid = ifRvalid_q;
    assign bus.if_rdata  = ifRvalid_q ? bus.ram_data : 32'h0;
    assign bus.d_rvalid  = dRvalid_q;
    assign bus.d_rdata   = dRvalid_q ? bus.ram_data : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a per-cycle vector table plus a reset-during-merge sequence,
// with a behavioural word RAM that latches its read address at the clock edge.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int AW = RAM_ADDRESS_BITWIDTH;

    typedef struct {
        logic          rst;
        logic          ifV;
        logic [AW-1:0] ifA;
        logic          dV;
        logic          dWe;
        logic [3:0]    dBe;
        logic [AW-1:0] dA;
        logic [31:0]   dWd;
        logic          eIfRdy;
        logic          eDRdy;
        logic          eWren;
        logic [AW-1:0] eRamA;
        logic [31:0]   eRamWd;
        logic          eIfRv;
        logic [31:0]   eIfRd;
        logic          eDRv;
        logic [31:0]   eDRd;
    } vec_t;

    logic          clk;
    logic          rst;
    int            checks;
    int            errors;
    logic [31:0]   mem [RAM_SIZE/4];
    logic [AW-1:0] ramAddrQ;
    vec_t          tbl [19];
    vec_t          hs  [5];

    ram_arbiter_if #(.ADDR_W(AW)) bus ();

    ram_arbiter #(.ADDR_W(AW), .RR_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: write at the edge, read data follows the address latched at the edge.
    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_address[AW-1:2]] <= bus.ram_write_data;
        ramAddrQ <= bus.ram_address;
    end
    assign bus.ram_data = mem[ramAddrQ[AW-1:2]];

    function automatic vec_t mk(input logic rst_, input logic ifV, input logic [AW-1:0] ifA,
                                input logic dV, input logic dWe, input logic [3:0] dBe,
                                input logic [AW-1:0] dA, input logic [31:0] dWd,
                                input logic eIfRdy, input logic eDRdy, input logic eWren,
                                input logic [AW-1:0] eRamA, input logic [31:0] eRamWd,
                                input logic eIfRv, input logic [31:0] eIfRd,
                                input logic eDRv, input logic [31:0] eDRd);
        vec_t v;
        v.rst = rst_; v.ifV = ifV; v.ifA = ifA; v.dV = dV; v.dWe = dWe; v.dBe = dBe;
        v.dA = dA; v.dWd = dWd; v.eIfRdy = eIfRdy; v.eDRdy = eDRdy; v.eWren = eWren;
        v.eRamA = eRamA; v.eRamWd = eRamWd; v.eIfRv = eIfRv; v.eIfRd = eIfRd;
        v.eDRv = eDRv; v.eDRd = eDRd;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst              = v.rst;
        bus.if_req_valid = v.ifV;
        bus.if_addr      = v.ifA;
        bus.d_req_valid  = v.dV;
        bus.d_we         = v.dWe;
        bus.d_be         = v.dBe;
        bus.d_addr       = v.dA;
        bus.d_wdata      = v.dWd;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        check({tag, " if_req_ready"},   32'(bus.if_req_ready),   32'(v.eIfRdy));
        check({tag, " d_req_ready"},    32'(bus.d_req_ready),    32'(v.eDRdy));
        check({tag, " ram_wren"},       32'(bus.ram_wren),       32'(v.eWren));
        check({tag, " ram_address"},    32'(bus.ram_address),    32'(v.eRamA));
        check({tag, " ram_write_data"}, bus.ram_write_data,      v.eRamWd);
        check({tag, " if_rvalid"},      32'(bus.if_rvalid),      32'(v.eIfRv));
        check({tag, " if_rdata"},       bus.if_rdata,            v.eIfRd);
        check({tag, " d_rvalid"},       32'(bus.d_rvalid),       32'(v.eDRv));
        check({tag, " d_rdata"},        bus.d_rdata,             v.eDRd);
    endtask

    // One cycle: drive just after the edge, compare on the falling edge.
    task automatic runVec(input vec_t v, input string tag);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        ramAddrQ = '0;
        for (int i = 0; i < RAM_SIZE/4; i++) mem[i] = 32'h0;
        mem['h10 >> 2] = 32'hDEADBEEF;
        mem['h14 >> 2] = 32'hCAFEF00D;
        mem['h18 >> 2] = 32'h01020304;
        mem['h30 >> 2] = 32'h12345678;
        mem['h40 >> 2] = 32'hA5A5A5A5;

        //           rst ifV ifA     dV we be     dA      dWd           ifRdy dRdy wren ramA  ramWd        ifRv ifRd          dRv dRd
        tbl[0]  = mk(1, 1, 'h010, 1, 0, 4'h0, 'h014, 32'h0,        0, 0, 0, 'h000, 32'h0,        0, 32'h0,        0, 32'h0);
        tbl[1]  = mk(0, 1, 'h010, 0, 0, 4'h0, 'h000, 32'h0,        1, 0, 0, 'h010, 32'h0,        0, 32'h0,        0, 32'h0);
        tbl[2]  = mk(0, 0, 'h000, 0, 0, 4'h0, 'h000, 32'h0,        0, 0, 0, 'h000, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0);
        tbl[3]  = mk(0, 1, 'h010, 1, 0, 4'h0, 'h014, 32'h0,        0, 1, 0, 'h014, 32'h0,        0, 32'h0,        0, 32'h0);
        tbl[4]  = mk(0, 1, 'h010, 1, 0, 4'h0, 'h018, 32'h0,        1, 0, 0, 'h010, 32'h0,        0, 32'h0,        1, 32'hCAFEF00D);
        tbl[5]  = mk(0, 1, 'h017, 1, 0, 4'h0, 'h018, 32'h0,        0, 1, 0, 'h018, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0);
        tbl[6]  = mk(0, 1, 'h017, 1, 0, 4'h0, 'h010, 32'h0,        1, 0, 0, 'h014, 32'h0,        0, 32'h0,        1, 32'h01020304);
        tbl[7]  = mk(0, 0, 'h000, 1, 0, 4'h0, 'h010, 32'h0,        0, 1, 0, 'h010, 32'h0,        1, 32'hCAFEF00D, 0, 32'h0);
        tbl[8]  = mk(0, 0, 'h000, 1, 1, 4'hF, 'h020, 32'h11223344, 0, 1, 1, 'h020, 32'h11223344, 0, 32'h0,        1, 32'hDEADBEEF);
        tbl[9]  = mk(0, 0, 'h000, 1, 0, 4'h0, 'h020, 32'h0,        0, 1, 0, 'h020, 32'h0,        0, 32'h0,        0, 32'h0);
        tbl[10] = mk(0, 0, 'h000, 1, 1, 4'hF, 'h020, 32'hAABBCCDD, 0, 1, 1, 'h020, 32'hAABBCCDD, 0, 32'h0,        1, 32'h11223344);
        tbl[11] = mk(0, 0, 'h000, 1, 1, 4'h2, 'h020, 32'h00001100, 0, 1, 0, 'h020, 32'h0,        0, 32'h0,        0, 32'h0);
        tbl[12] = mk(0, 1, 'h010, 1, 0, 4'h0, 'h020, 32'h0,        0, 0, 1, 'h020, 32'hAABB11DD, 0, 32'h0,        0, 32'h0);
        tbl[13] = mk(0, 1, 'h010, 1, 0, 4'h0, 'h020, 32'h0,        1, 0, 0, 'h010, 32'h0,        0, 32'h0,        0, 32'h0);
        tbl[14] = mk(0, 0, 'h000, 1, 0, 4'h0, 'h020, 32'h0,        0, 1, 0, 'h020, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0);
        tbl[15] = mk(0, 0, 'h000, 0, 0, 4'h0, 'h000, 32'h0,        0, 0, 0, 'h000, 32'h0,        0, 32'h0,        1, 32'hAABB11DD);
        tbl[16] = mk(0, 0, 'h000, 1, 1, 4'h0, 'h030, 32'hFFFFFFFF, 0, 1, 0, 'h000, 32'h0,        0, 32'h0,        0, 32'h0);
        tbl[17] = mk(0, 0, 'h000, 1, 0, 4'h0, 'h032, 32'h0,        0, 1, 0, 'h030, 32'h0,        0, 32'h0,        0, 32'h0);
        tbl[18] = mk(0, 0, 'h000, 0, 0, 4'h0, 'h000, 32'h0,        0, 0, 0, 'h000, 32'h0,        0, 32'h0,        1, 32'h12345678);

        // Reset during the merge cycle of a byte-0 store to 0x40, then a reload.
        hs[0] = mk(0, 0, 'h000, 1, 1, 4'h1, 'h040, 32'h000000EE, 0, 1, 0, 'h040, 32'h0, 0, 32'h0, 0, 32'h0);
        hs[1] = mk(1, 0, 'h000, 0, 0, 4'h0, 'h000, 32'h0,        0, 0, 0, 'h000, 32'h0, 0, 32'h0, 0, 32'h0);
        hs[2] = mk(0, 0, 'h000, 0, 0, 4'h0, 'h000, 32'h0,        0, 0, 0, 'h000, 32'h0, 0, 32'h0, 0, 32'h0);
        hs[3] = mk(0, 0, 'h000, 1, 0, 4'h0, 'h040, 32'h0,        0, 1, 0, 'h040, 32'h0, 0, 32'h0, 0, 32'h0);
        hs[4] = mk(0, 0, 'h000, 0, 0, 4'h0, 'h000, 32'h0,        0, 0, 0, 'h000, 32'h0, 0, 32'h0, 1, 32'hA5A5A5A5);

        applyStimulus(tbl[0]);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            runVec(tbl[i], $sformatf("row%0d", i));
        end

        for (int i = 0; i < 5; i++) begin
            runVec(hs[i], $sformatf("rstmerge%0d", i));
            if (i == 2) check("rstmerge word0x40", mem['h40 >> 2], 32'hA5A5A5A5);
        end
        check("bestore word0x30", mem['h30 >> 2], 32'h12345678);
        check("rmw word0x20",     mem['h20 >> 2], 32'hAABB11DD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
